// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes.
// Add/sub/inc/dec and logic ops finish in one cycle. Shifts by n > 0 are
// iterated one bit per cycle in a small shift register.
//
// state | meaning
// IDLE  | waiting for an operand/op transfer
// SHIFT | iterating a multi-bit shift, counter holds remaining steps
// DONE  | result presented, waiting for the consumer
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             load_shift;
  logic [WIDTH-1:0] sreg;
  logic [SW-1:0]    cnt;
  logic             is_lsl;
  logic             sign;

  logic [WIDTH-1:0] y_op;
  logic             cin;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   imm_res;
  logic             imm_v;
  logic [WIDTH-1:0] step_data;
  logic             step_ext;

  // Single-cycle datapath: adder operand select, logic unit, n=0 shifts.
  always_comb begin
    y_op      = b;
    cin       = 1'b0;
    logic_res = a ^ b;
    imm_res   = '0;
    imm_v     = 1'b0;
    case (op[1:0])
      2'b00: begin y_op = b;  cin = 1'b0; end
      2'b01: begin y_op = ~b; cin = 1'b1; end
      2'b10: begin y_op = '0; cin = 1'b1; end
      default: begin y_op = '1; cin = 1'b0; end
    endcase
    sum_full = {1'b0, a} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
    case (op[1:0])
      2'b10:   logic_res = a | b;
      2'b11:   logic_res = a & b;
      default: logic_res = a ^ b;
    endcase
    if (op[3:2] == 2'b00) begin
      imm_res = sum_full;
      imm_v   = (a[WIDTH-1] == y_op[WIDTH-1]) && (sum_full[WIDTH-1] != a[WIDTH-1]);
    end else if (op[3:2] == 2'b01) begin
      imm_res = {1'b0, logic_res};
    end else if (op[3:2] == 2'b10) begin
      // ASR by zero still reports the sign in the extra bit.
      imm_res = {a[WIDTH-1], a};
    end else begin
      imm_res = {1'b0, a};
    end
  end

  // One shift step; the extra bit is the sign for ASR, the bit falling off for LSL.
  always_comb begin
    step_data = is_lsl ? {sreg[WIDTH-2:0], 1'b0} : {sreg[WIDTH-1], sreg[WIDTH-1:1]};
    step_ext  = is_lsl ? sreg[WIDTH-1] : sign;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake outputs and accept decode.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = (state == DONE);
    load_shift = op[3] && (b[SW-1:0] != '0);
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
    accept = in_valid && in_ready;
    case (state)
      IDLE: begin
        if (accept) state_nxt = load_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == SW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = load_shift ? SHIFT : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: load on accept, iterate while shifting, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg   <= '0;
      cnt    <= '0;
      is_lsl <= 1'b0;
      sign   <= 1'b0;
      result <= '0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      if (load_shift) begin
        sreg   <= a;
        cnt    <= b[SW-1:0];
        is_lsl <= op[2];
        sign   <= a[WIDTH-1];
      end else begin
        result <= imm_res;
        flag_z <= (imm_res[WIDTH-1:0] == '0);
        flag_v <= imm_v;
      end
    end else if (state == SHIFT) begin
      sreg <= step_data;
      cnt  <= cnt - SW'(1);
      if (cnt == SW'(1)) begin
        result <= {step_ext, step_data};
        flag_z <= (step_data == '0);
        flag_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed stimulus for alu_seq (WIDTH=8) with a scoreboard of
// expected results checked whenever an output handshake completes.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         flag_z;
  logic         flag_v;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [8:0] r;
    logic       z;
    logic       v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_v(flag_v)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model written with plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int r, s, sx, sy, n;
    sx = $signed(x);
    sy = $signed(y);
    n  = int'(y[2:0]);
    r  = 0;
    s  = 0;
    casez (o)
      4'b0000: begin r = x + y;             s = sx + sy; end
      4'b0001: begin r = x + (255 - y) + 1; s = sx - sy; end
      4'b0010: begin r = x + 1;             s = sx + 1;  end
      4'b0011: begin r = x + 255;           s = sx - 1;  end
      4'b010?: r = x ^ y;
      4'b0110: r = x | y;
      4'b0111: r = x & y;
      4'b10??: r = ((sx >>> n) & 255) | (x[7] ? 256 : 0);
      default: r = ((x << n) & 255) | ((n != 0) ? (((x >> (8 - n)) & 1) << 8) : 0);
    endcase
    e.r = r[8:0];
    e.z = (r[7:0] == 8'h00);
    e.v = (o[3:2] == 2'b00) && (s > 127 || s < -128);
    return e;
  endfunction

  // Presents one op, waits (bounded) for acceptance, records the expectation.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, output int w);
    op = o; a = x; b = y; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(o, x, y));
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from just after the accept edge until out_valid; in_ready must stay low meanwhile.
  task automatic wait_valid(output int c);
    c = 0;
    while (!out_valid && c < 40) begin
      chk("busy_in_ready", in_ready, 0);
      tick();
      c++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && out_valid; i++) tick();
    chk("drained", out_valid, 0);
  endtask

  // Scoreboard: compare every completed output handshake against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", 32'(result), 32'(e.r));
        chk("sb_flag_z", 32'(flag_z), 32'(e.z));
        chk("sb_flag_v", 32'(flag_v), 32'(e.v));
      end
    end
  end

  initial begin
    int w, c;
    logic [8:0] held;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;

    // Reset for two cycles: every output low.
    tick();
    chk("rst_outputs_1", {out_valid, in_ready, result, flag_z, flag_v}, 0);
    tick();
    chk("rst_outputs_2", {out_valid, in_ready, result, flag_z, flag_v}, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Add with signed overflow, one-cycle latency.
    send(4'b0000, 8'h7F, 8'h01, w);
    chk("add_latency", out_valid, 1);
    chk("add_result", result, 9'h080);
    chk("add_v", flag_v, 1);
    chk("add_z", flag_z, 0);
    tick();
    chk("add_one_cycle", out_valid, 0);

    // Arithmetic and logic ops streamed back to back.
    send(4'b0001, 8'h05, 8'h07, w);
    send(4'b0001, 8'h07, 8'h05, w);
    send(4'b0010, 8'hFF, 8'h00, w);
    send(4'b0011, 8'h00, 8'h00, w);
    send(4'b0100, 8'hF0, 8'h3C, w);
    send(4'b0101, 8'hA5, 8'hA5, w);
    send(4'b0110, 8'hF0, 8'h0F, w);
    send(4'b0111, 8'hF0, 8'h0F, w);
    send(4'b0001, 8'h80, 8'h01, w);
    send(4'b0010, 8'h7F, 8'h00, w);
    send(4'b0011, 8'h80, 8'h00, w);
    chk("stream_no_wait", w, 0);
    drain();

    // ASR by 3: four-cycle latency; inputs changed after accept have no effect.
    send(4'b1000, 8'h90, 8'h03, w);
    a = 8'h00; b = 8'hFF; op = 4'b1100;
    wait_valid(c);
    chk("asr3_latency", c + 1, 4);
    chk("asr3_result", result, 9'h1F2);
    drain();

    // LSL by 1, ASR by 0 (upper bits of b ignored), LSL by 0 and by 7.
    send(4'b1100, 8'h81, 8'h01, w);
    wait_valid(c);
    chk("lsl1_latency", c + 1, 2);
    drain();
    send(4'b1000, 8'h90, 8'hF8, w);
    chk("asr0_latency", out_valid, 1);
    drain();
    send(4'b1111, 8'h81, 8'h00, w);
    drain();
    send(4'b1101, 8'h03, 8'h07, w);
    wait_valid(c);
    chk("lsl7_latency", c + 1, 8);
    drain();

    // Backpressure: result held and no accept while out_ready is low.
    out_ready = 1'b0;
    send(4'b0000, 8'h12, 8'h34, w);
    held = result;
    op = 4'b0110; a = 8'h0C; b = 8'h30; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", result, held);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    sb.push_back(model(4'b0110, 8'h0C, 8'h30));
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_result", result, 9'h03C);
    drain();

    // Four adds with out_ready high: four consecutive valid cycles.
    send(4'b0000, 8'h01, 8'h02, w);
    chk("burst_valid_0", out_valid, 1);
    send(4'b0000, 8'hFF, 8'h01, w);
    chk("burst_valid_1", out_valid, 1);
    chk("burst_wait_1", w, 0);
    send(4'b0000, 8'h80, 8'h80, w);
    chk("burst_valid_2", out_valid, 1);
    chk("burst_wait_2", w, 0);
    send(4'b0000, 8'h40, 8'h40, w);
    chk("burst_valid_3", out_valid, 1);
    chk("burst_wait_3", w, 0);
    drain();

    // Reset in the third SHIFT cycle of an ASR by 7: result never presented.
    send(4'b1000, 8'h80, 8'h07, w);
    seen = out_valid;
    tick();
    seen = seen | out_valid;
    tick();
    seen = seen | out_valid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_outputs", {out_valid, result, flag_z, flag_v}, 0);
    for (int i = 0; i < 10; i++) begin
      seen = seen | out_valid;
      tick();
    end
    chk("midrst_no_valid", seen, 0);

    // Next op after the abort: ASR by WIDTH-1 gives all sign bits.
    send(4'b1000, 8'h80, 8'h07, w);
    wait_valid(c);
    chk("asr7_latency", c + 1, 8);
    chk("asr7_result", result, 9'h1FF);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
